// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbitration bus: pipeline write-back, debug-host handshake, write port.
// Optional REGFILE_ARB_STATS_EN adds the Host_Defer_Count statistics signal.
interface regfile_write_arbiter_if;
    logic        RegWrite_WB;
    logic [4:0]  Write_Register_WB;
    logic [31:0] Write_Data_WB;
    logic        Host_Req;
    logic [4:0]  Host_Addr;
    logic [31:0] Host_Data;
    logic        Start_Clear;
    logic        Host_Ack;
    logic        Rf_We;
    logic [4:0]  Rf_Addr;
    logic [31:0] Rf_Data;
    logic        Busy;
    logic        Freeze_Req;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] Host_Defer_Count;
`endif

    modport master (
        output RegWrite_WB, Write_Register_WB, Write_Data_WB,
        output Host_Req, Host_Addr, Host_Data, Start_Clear,
        input  Host_Ack, Rf_We, Rf_Addr, Rf_Data, Busy, Freeze_Req
`ifdef REGFILE_ARB_STATS_EN
        , input Host_Defer_Count
`endif
    );

    modport slave (
        input  RegWrite_WB, Write_Register_WB, Write_Data_WB,
        input  Host_Req, Host_Addr, Host_Data, Start_Clear,
        output Host_Ack, Rf_We, Rf_Addr, Rf_Data, Busy, Freeze_Req
`ifdef REGFILE_ARB_STATS_EN
        , output Host_Defer_Count
`endif
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates pipeline write-back, debug-host writes and a register-file clear sweep.
// Define REGFILE_ARB_STATS_EN to add the saturating Host_Defer_Count statistic.
module regfile_write_arbiter (
    input logic                    Clk,
    input logic                    Reset_n,
    regfile_write_arbiter_if.slave bus
);

    typedef enum logic {StClear, StRun} state_e;

    state_e      state_q, state_d;
    logic [4:0]  clr_cnt_q, clr_cnt_d;
    logic [2:0]  defer_q, defer_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_data_q, rf_data_d;
    logic        ack_q, ack_d;
    logic        freeze_q, freeze_d;
    logic        wb_valid, host_grant, defer_inc;

    // Writes to register 0 are discarded, so they never claim the port.
    assign wb_valid   = bus.RegWrite_WB && (bus.Write_Register_WB != 5'd0);
    // Ack cycle blocks a re-grant while the host still sees its request high.
    assign host_grant = (state_q == StRun) && bus.Host_Req && !ack_q && !wb_valid &&
                        !bus.Start_Clear;
    assign defer_inc  = (state_q == StRun) && bus.Host_Req && !ack_q && wb_valid;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: begin
                if (!bus.Start_Clear && !wb_valid && (clr_cnt_q == 5'd31)) state_d = StRun;
            end
            StRun: begin
                if (bus.Start_Clear) state_d = StClear;
            end
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        ack_d     = 1'b0;
        clr_cnt_d = clr_cnt_q;
        defer_d   = defer_q;

        if (wb_valid) begin
            rf_we_d   = 1'b1;
            rf_addr_d = bus.Write_Register_WB;
            rf_data_d = bus.Write_Data_WB;
        end

        unique case (state_q)
            StClear: begin
                if (!wb_valid) begin
                    rf_we_d   = 1'b1;
                    rf_addr_d = clr_cnt_q;
                    rf_data_d = 32'd0;
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
                if (bus.Start_Clear) clr_cnt_d = 5'd1;
            end
            StRun: begin
                if (bus.Start_Clear) begin
                    clr_cnt_d = 5'd1;
                end else if (host_grant) begin
                    ack_d     = 1'b1;
                    rf_we_d   = (bus.Host_Addr != 5'd0);
                    rf_addr_d = bus.Host_Addr;
                    rf_data_d = bus.Host_Data;
                end
            end
            default: clr_cnt_d = 5'd1;
        endcase

        if (!bus.Host_Req || host_grant) begin
            defer_d = 3'd0;
        end else if (defer_inc && (defer_q != 3'd7)) begin
            defer_d = defer_q + 3'd1;
        end
        freeze_d = (defer_d == 3'd7);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clr_cnt_q <= 5'd1;
            defer_q   <= 3'd0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= 5'd0;
            rf_data_q <= 32'd0;
            ack_q     <= 1'b0;
            freeze_q  <= 1'b0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
            defer_q   <= defer_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            ack_q     <= ack_d;
            freeze_q  <= freeze_d;
        end
    end

    assign bus.Rf_We      = rf_we_q;
    assign bus.Rf_Addr    = rf_addr_q;
    assign bus.Rf_Data    = rf_data_q;
    assign bus.Host_Ack   = ack_q;
    assign bus.Freeze_Req = freeze_q;
    assign bus.Busy       = (state_q == StClear);

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] stats_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stats_q <= 16'd0;
        end else if (defer_inc && (stats_q != 16'hFFFF)) begin
            stats_q <= stats_q + 16'd1;
        end
    end

    assign bus.Host_Defer_Count = stats_q;
`else
    // Without statistics only Freeze_Req reflects host deferral.
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle model predicts each registered output.
module tb_regfile_write_arbiter;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    always #5 Clk = ~Clk;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ack;
        logic        busy;
        logic        freeze;
        logic [15:0] stats;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: clear sweep position, host deferral run length, visible ack/freeze.
    bit m_clear;
    int m_cnt;
    int m_defer;
    bit m_ack;
    bit m_freeze;
    int m_stats;

    task automatic model_reset();
        m_clear  = 1'b1;
        m_cnt    = 1;
        m_defer  = 0;
        m_ack    = 1'b0;
        m_freeze = 1'b0;
        m_stats  = 0;
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.we = 1'b0; e.addr = 5'd0; e.data = 32'd0; e.ack = 1'b0;
        e.busy = 1'b1; e.freeze = 1'b0; e.stats = 16'd0;
        return e;
    endfunction

    task automatic check(input exp_t e, input bit full);
        bit bad;
        bad = (bus.Rf_We !== e.we) || (bus.Host_Ack !== e.ack) || (bus.Busy !== e.busy) ||
              (bus.Freeze_Req !== e.freeze);
        if (full || e.we) bad = bad || (bus.Rf_Addr !== e.addr) || (bus.Rf_Data !== e.data);
`ifdef REGFILE_ARB_STATS_EN
        bad = bad || (bus.Host_Defer_Count !== e.stats);
`endif
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s @%0t: got we=%b addr=%0d data=%h ack=%b busy=%b frz=%b, want we=%b addr=%0d data=%h ack=%b busy=%b frz=%b",
                     full ? "reset_outputs" : "cycle_outputs", $time, bus.Rf_We, bus.Rf_Addr,
                     bus.Rf_Data, bus.Host_Ack, bus.Busy, bus.Freeze_Req, e.we, e.addr, e.data,
                     e.ack, e.busy, e.freeze);
        end
    endtask

    // Monitor: reset values checked right after reset assertion and on each edge in reset.
    always begin
        @(posedge Clk or negedge Reset_n);
        #1;
        if (!Reset_n) begin
            check(reset_exp(), 1'b1);
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check(mon_e, 1'b0);
        end
    end

    // One cycle of stimulus; the model predicts the outputs after the coming edge.
    task automatic step(input bit wb_we, input logic [4:0] wb_a, input logic [31:0] wb_d,
                        input bit sc, input bit hnew, input logic [4:0] ha,
                        input logic [31:0] hd);
        exp_t e;
        bit   wb_ok;
        bit   grant;
        @(negedge Clk);
        if (m_ack) begin
            bus.Host_Req = 1'b0;
        end else if (hnew && !bus.Host_Req) begin
            bus.Host_Req  = 1'b1;
            bus.Host_Addr = ha;
            bus.Host_Data = hd;
        end
        bus.RegWrite_WB       = wb_we;
        bus.Write_Register_WB = wb_a;
        bus.Write_Data_WB     = wb_d;
        bus.Start_Clear       = sc;

        wb_ok = wb_we && (wb_a != 5'd0);
        grant = 1'b0;
        e.we = 1'b0; e.addr = 5'd0; e.data = 32'd0;
        if (wb_ok) begin
            e.we = 1'b1; e.addr = wb_a; e.data = wb_d;
        end
        if (m_clear) begin
            if (!wb_ok) begin
                e.we = 1'b1; e.addr = m_cnt[4:0]; e.data = 32'd0;
                if (m_cnt == 31) begin
                    if (!sc) m_clear = 1'b0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (sc) m_cnt = 1;
        end else begin
            if (sc) begin
                m_clear = 1'b1;
                m_cnt   = 1;
            end else if (bus.Host_Req && !m_ack && !wb_ok) begin
                grant  = 1'b1;
                e.we   = (bus.Host_Addr != 5'd0);
                e.addr = bus.Host_Addr;
                e.data = bus.Host_Data;
            end
            if (bus.Host_Req && !m_ack && wb_ok) begin
                if (m_defer < 7) m_defer = m_defer + 1;
                if (m_stats < 65535) m_stats = m_stats + 1;
            end
        end
        if (!bus.Host_Req || grant) m_defer = 0;
        m_ack    = grant;
        m_freeze = (m_defer == 7);
        e.ack = m_ack; e.busy = m_clear; e.freeze = m_freeze; e.stats = 16'(m_stats);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic clear_inputs();
        bus.RegWrite_WB = 1'b0; bus.Write_Register_WB = 5'd0; bus.Write_Data_WB = 32'd0;
        bus.Host_Req = 1'b0; bus.Host_Addr = 5'd0; bus.Host_Data = 32'd0;
        bus.Start_Clear = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        @(negedge Clk);
        Reset_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        model_reset();
        repeat (hold) @(posedge Clk);
        #2 Reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;

        // Full clear sweep after reset, then settle in RUN.
        idle(34);

        // WB and host in the same cycle: WB first, host one cycle later with a single ack.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 5'd6, 32'h0000_1234);
        idle(4);

        // Host starved by continuous WB until Freeze_Req suppresses the pipeline.
        step(1'b1, 5'd3, 32'h1111_0000, 1'b0, 1'b1, 5'd7, 32'hCAFE_F00D);
        for (int i = 0; i < 14; i++) begin
            step(!m_freeze, 5'(i + 1), 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0, 5'd0, 32'd0);
        end
        idle(3);

        // Host write to register 0 is acked without a write.
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'h0BAD_0BAD);
        idle(3);

        // Re-clear with a WB write to register 9 slipped into the sweep.
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        idle(5);
        step(1'b1, 5'd9, 32'h9999_9999, 1'b0, 1'b1, 5'd2, 32'h2222_2222);
        idle(36);

        // Reset while clear address 12 is being written; sweep restarts at 1.
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 40 && !(m_clear && m_cnt == 13); i++) idle(1);
        do_reset(2);
        idle(35);

        // Randomized traffic with occasional clears and mid-run resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 2) != 0) && !m_freeze, 5'($urandom), $urandom,
                 ($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), 5'($urandom),
                 $urandom);
            if ($urandom_range(0, 499) == 0) do_reset(1);
        end

        repeat (2) @(posedge Clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
